melody_seq_player: RTL and testbench

//  Single-clock, parametrised music sequencer. Replaces the 4 Hz note-counter / ROM / tone-code / speaker

---
 rtl/melody_seq_player_pkg.sv | 49 ++++
 rtl/melody_seq_player_if.sv | 32 +++
 rtl/melody_seq_player_tone_divider.sv | 41 ++++
 rtl/melody_seq_player.sv | 172 +++++++++++++++++
 tb/tb_melody_seq_player.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/melody_seq_player_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// melody_seq_player_pkg : note codes, sequencer states, tone table
// Rev 1.0
// ------------------------------------------------------------------
package melody_seq_player_pkg;

   localparam logic [3:0] c_CODE_REST = 4'd0;
   localparam logic [3:0] c_CODE_END  = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_PLAY  = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;

   typedef struct packed {
      logic [10:0] tn;
      logic [3:0]  octave;
      logic [3:0]  degree;
   } tone_t;

   // TN = 2048 - 1e6/(2*f); codes 1..7 are C4..B4, codes 8..14 are C5..B5
   function automatic tone_t tone_lookup(input logic [3:0] code);
      tone_t t;
      t = '0;
      case (code)
         4'd1:  t = '{11'd140,  4'd1, 4'd1};
         4'd2:  t = '{11'd347,  4'd1, 4'd2};
         4'd3:  t = '{11'd533,  4'd1, 4'd3};
         4'd4:  t = '{11'd615,  4'd1, 4'd4};
         4'd5:  t = '{11'd772,  4'd1, 4'd5};
         4'd6:  t = '{11'd912,  4'd1, 4'd6};
         4'd7:  t = '{11'd1036, 4'd1, 4'd7};
         4'd8:  t = '{11'd1092, 4'd2, 4'd1};
         4'd9:  t = '{11'd1196, 4'd2, 4'd2};
         4'd10: t = '{11'd1289, 4'd2, 4'd3};
         4'd11: t = '{11'd1332, 4'd2, 4'd4};
         4'd12: t = '{11'd1410, 4'd2, 4'd5};
         4'd13: t = '{11'd1480, 4'd2, 4'd6};
         4'd14: t = '{11'd1542, 4'd2, 4'd7};
         default: t = '0;
      endcase
      return t;
   endfunction

endpackage
`default_nettype wire

// File: rtl/melody_seq_player_if.sv
`default_nettype none
// ------------------------------------------------------------------
// melody_seq_player_if : key inputs, note ROM port, speaker and display
// Rev 1.0
// ------------------------------------------------------------------
interface melody_seq_player_if #(
   parameter int SEL_W = 2,
   parameter int IDX_W = 8
);
   logic                   i_start;
   logic                   i_stop;
   logic                   i_pause;
   logic                   i_loop;
   logic [SEL_W-1:0]       i_song_sel;
   logic [3:0]             i_rom_q;
   logic [SEL_W+IDX_W-1:0] o_rom_addr;
   logic                   o_spks;
   logic [15:0]            o_display_num;
   logic                   o_busy;
   logic                   o_done;

   modport slave (
      input  i_start, i_stop, i_pause, i_loop, i_song_sel, i_rom_q,
      output o_rom_addr, o_spks, o_display_num, o_busy, o_done
   );

   modport master (
      output i_start, i_stop, i_pause, i_loop, i_song_sel, i_rom_q,
      input  o_rom_addr, o_spks, o_display_num, o_busy, o_done
   );
endinterface
`default_nettype wire

// File: rtl/melody_seq_player_tone_divider.sv
`default_nettype none
// ------------------------------------------------------------------
// melody_seq_player_tone_divider : preset up-counter, toggles at all-ones
// Rev 1.0
// ------------------------------------------------------------------
module melody_seq_player_tone_divider #(
   parameter int TN_W = 11
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_en,
   input  logic            i_load,
   input  logic [TN_W-1:0] i_tn,
   output logic            o_spks
);
   logic [TN_W-1:0] r_cnt;
   logic [TN_W-1:0] r_tn;
   logic            r_spks;

   // Loading a new note keeps the output phase so consecutive tones join smoothly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_tn   <= '0;
         r_spks <= 1'b0;
      end else if (i_load) begin
         r_cnt <= i_tn;
         r_tn  <= i_tn;
      end else if (i_en) begin
         if (&r_cnt) begin
            r_cnt  <= r_tn;
            r_spks <= ~r_spks;
         end else begin
            r_cnt <= r_cnt + TN_W'(1);
         end
      end
   end

   assign o_spks = r_spks;
endmodule
`default_nettype wire

// File: rtl/melody_seq_player.sv
`default_nettype none
// ------------------------------------------------------------------
// melody_seq_player : beat prescaler, multi-song sequencer, tone lookup
// Rev 1.0
// ------------------------------------------------------------------
module melody_seq_player
   import melody_seq_player_pkg::*;
#(
   parameter int                     CLK_HZ       = 1_000_000,
   parameter int                     BEAT_HZ      = 4,
   parameter int                     NUM_SONGS    = 4,
   parameter int                     SONG_DEPTH   = 256,
   parameter int                     TN_W         = 11,
   parameter bit                     USE_TN_TABLE = 1'b0,
   parameter logic [15:0][TN_W-1:0]  TN_TABLE     = '0
) (
   input  logic               clk,
   input  logic               rst,
   melody_seq_player_if.slave bus
);
   localparam int c_BEAT_DIV = CLK_HZ / BEAT_HZ;
   localparam int c_SEL_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
   localparam int c_IDX_W    = $clog2(SONG_DEPTH);
   localparam int c_PRE_W    = $clog2(c_BEAT_DIV);

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_ph;
   logic [c_SEL_W-1:0]   r_song;
   logic [c_IDX_W-1:0]   r_idx;
   logic [c_PRE_W-1:0]   r_pre;
   logic [3:0]           r_code;
   logic [15:0]          r_disp;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_restart;
   logic                 w_cap;
   logic                 w_adv;
   logic                 w_wrap;
   logic                 w_finish;
   logic                 w_run;
   logic                 w_pre_tc;
   logic                 w_idx_last;
   logic                 w_is_end;
   logic                 w_div_en;
   logic                 w_div_spks;
   tone_t                w_tone;
   logic [TN_W-1:0]      w_tn;

   assign w_pre_tc   = (r_pre == c_PRE_W'(c_BEAT_DIV - 1));
   assign w_idx_last = (r_idx == c_IDX_W'(SONG_DEPTH - 1));
   assign w_is_end   = (bus.i_rom_q == c_CODE_END);
   assign w_tone     = tone_lookup(bus.i_rom_q);
   assign w_tn       = USE_TN_TABLE ? TN_TABLE[bus.i_rom_q] : TN_W'(w_tone.tn);

   // A cycle only advances the note when nothing preempts it; PAUSE state resumes the same cycle PAUSE drops
   assign w_run    = ((r_state == ST_PLAY) || (r_state == ST_PAUSE)) &&
                     !bus.i_pause && !bus.i_start && !bus.i_stop;
   assign w_div_en = w_run && (r_code != c_CODE_REST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_restart   = 1'b0;
      w_cap       = 1'b0;
      w_adv       = 1'b0;
      w_wrap      = 1'b0;
      w_finish    = 1'b0;
      if (bus.i_stop) begin
         w_state_nxt = ST_IDLE;
      end else if (bus.i_start) begin
         w_state_nxt = ST_FETCH;
         w_restart   = 1'b1;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (r_ph) begin
                  if (!w_is_end) begin
                     w_state_nxt = ST_PLAY;
                     w_cap       = 1'b1;
                  end else if (bus.i_loop) begin
                     w_wrap = 1'b1;
                  end else begin
                     w_finish    = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            ST_PLAY, ST_PAUSE: begin
               if (bus.i_pause) begin
                  w_state_nxt = ST_PAUSE;
               end else if (w_pre_tc) begin
                  if (!w_idx_last) begin
                     w_adv       = 1'b1;
                     w_state_nxt = ST_FETCH;
                  end else if (bus.i_loop) begin
                     w_wrap      = 1'b1;
                     w_state_nxt = ST_FETCH;
                  end else begin
                     w_finish    = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_state_nxt = ST_PLAY;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ph   <= 1'b0;
         r_song <= '0;
         r_idx  <= '0;
         r_pre  <= '0;
         r_code <= '0;
         r_disp <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_finish;
         r_busy <= (w_state_nxt != ST_IDLE);
         // Second FETCH cycle is the one where the ROM data is valid
         r_ph   <= (r_state == ST_FETCH) && (w_state_nxt == ST_FETCH) && !r_ph && !w_restart;

         if (w_restart) begin
            r_song <= bus.i_song_sel;
            r_idx  <= '0;
         end else if (w_wrap) begin
            r_idx <= '0;
         end else if (w_adv) begin
            r_idx <= r_idx + c_IDX_W'(1);
         end

         if (bus.i_stop || w_restart) begin
            r_pre <= '0;
         end else if (w_run) begin
            r_pre <= w_pre_tc ? '0 : r_pre + c_PRE_W'(1);
         end

         if (w_cap) begin
            r_code <= bus.i_rom_q;
            r_disp <= {4'(r_song), w_tone.octave, w_tone.degree, bus.i_rom_q};
         end
      end
   end

   melody_seq_player_tone_divider #(
      .TN_W (TN_W)
   ) u_div (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_div_en),
      .i_load (w_cap),
      .i_tn   (w_tn),
      .o_spks (w_div_spks)
   );

   assign bus.o_rom_addr    = {r_song, r_idx};
   assign bus.o_spks        = w_div_spks & w_div_en;
   assign bus.o_display_num = r_disp;
   assign bus.o_busy        = r_busy;
   assign bus.o_done        = r_done;
endmodule
`default_nettype wire

// File: tb/tb_melody_seq_player.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_melody_seq_player : random and directed stimulus against a note-level model
// Rev 1.0
// ------------------------------------------------------------------
module tb_melody_seq_player;
   localparam int SEL_W = 2;
   localparam int IDX_W = 8;
   // Test tone presets: half period (cycles) per code is hp[] below, TN = 2048 - hp
   localparam logic [15:0][10:0] TB_TN = {11'd0, 11'd2046, 11'd2033, 11'd2036, 11'd2040,
                                          11'd2042, 11'd2044, 11'd2037, 11'd2039, 11'd2045,
                                          11'd2031, 11'd2043, 11'd2035, 11'd2041, 11'd2038, 11'd0};

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   melody_seq_player_if #(.SEL_W(SEL_W), .IDX_W(IDX_W)) bus ();

   melody_seq_player #(
      .CLK_HZ       (1000),
      .BEAT_HZ      (4),
      .NUM_SONGS    (4),
      .SONG_DEPTH   (256),
      .TN_W         (11),
      .USE_TN_TABLE (1'b1),
      .TN_TABLE     (TB_TN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [3:0] mem [0:1023];
   always @(posedge clk) bus.i_rom_q <= mem[bus.o_rom_addr];

   int hp [16] = '{0, 10, 7, 13, 5, 17, 3, 9, 11, 4, 6, 8, 12, 15, 2, 0};
   int n_checks = 0;
   int n_errors = 0;

   // Model: mode 0 idle, 1 fetching, 2 playing (paused or not)
   int          m_mode, m_fetch_left, m_song, m_idx, m_beat_left, m_code, m_phase, m_tog_left;
   logic [15:0] m_disp;
   logic        m_done, m_busy;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_fetch_left = 0; m_song = 0; m_idx = 0; m_beat_left = 0;
      m_code = 0; m_phase = 0; m_tog_left = 0; m_disp = '0; m_done = 1'b0; m_busy = 1'b0;
   endtask

   task automatic begin_fetch();
      m_mode = 1;
      m_fetch_left = 2;
   endtask

   task automatic song_end();
      if (bus.i_loop) begin
         m_idx = 0;
         begin_fetch();
      end else begin
         m_mode = 0;
         m_done = 1'b1;
      end
   endtask

   task automatic load_note(input int code);
      int oct, deg;
      if (code == 15) begin
         song_end();
      end else begin
         oct = (code == 0) ? 0 : ((code <= 7) ? 1 : 2);
         deg = (code == 0) ? 0 : ((code <= 7) ? code : code - 7);
         m_mode = 2;
         m_beat_left = 250;
         m_code = code;
         m_tog_left = hp[code];
         m_disp = {4'(m_song), 4'(oct), 4'(deg), 4'(code)};
      end
   endtask

   task automatic model_advance(input logic run);
      m_done = 1'b0;
      if (bus.i_stop) begin
         m_mode = 0;
      end else if (bus.i_start) begin
         m_song = int'(bus.i_song_sel);
         m_idx = 0;
         begin_fetch();
      end else if (m_mode == 1) begin
         m_fetch_left--;
         if (m_fetch_left == 0) load_note(int'(mem[m_song * 256 + m_idx]));
      end else if (run) begin
         m_beat_left--;
         if (m_code != 0) begin
            m_tog_left--;
            if (m_tog_left == 0) begin
               m_phase ^= 1;
               m_tog_left = hp[m_code];
            end
         end
         if (m_beat_left == 0) begin
            if (m_idx == 255) song_end();
            else begin
               m_idx++;
               begin_fetch();
            end
         end
      end
      m_busy = (m_mode != 0);
   endtask

   // Called at a negedge with this cycle's inputs applied; returns at the next negedge
   task automatic tick();
      logic run;
      #1;
      run = (m_mode == 2) && !bus.i_pause && !bus.i_start && !bus.i_stop && !rst;
      check_eq("rom_addr", 32'(bus.o_rom_addr), 32'((m_song << 8) | m_idx));
      check_eq("spks", 32'(bus.o_spks), 32'(run && (m_code != 0) && (m_phase != 0)));
      check_eq("display", 32'(bus.o_display_num), 32'(m_disp));
      check_eq("busy", 32'(bus.o_busy), 32'(m_busy));
      check_eq("done", 32'(bus.o_done), 32'(m_done));
      if (!rst) model_advance(run);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_start(input int sel, input logic loop_en);
      bus.i_song_sel = SEL_W'(sel);
      bus.i_loop = loop_en;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
   endtask

   task automatic run_to_done(input int max, output int n);
      n = 0;
      while (!bus.o_done && n < max) begin
         tick();
         n++;
      end
      if (n == max) check_eq("done_timeout", 32'(bus.o_done), 32'd1);
   endtask

   initial begin
      int n, hi, dones;
      bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_pause = 1'b0;
      bus.i_loop = 1'b0; bus.i_song_sel = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 4'd15;
      mem[0] = 4'd1;   mem[1] = 4'd0;   mem[2] = 4'd15;
      mem[256] = 4'd3; mem[257] = 4'd5; mem[258] = 4'd15;
      mem[512] = 4'd2; mem[513] = 4'd15;
      for (int i = 0; i < 256; i++) mem[768 + i] = 4'($urandom_range(0, 14));

      @(negedge clk);
      rst = 1'b1;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Song 0: 10-cycle tone for one beat, then a rest
      pulse_start(0, 1'b0);
      n = 0; hi = 0;
      while (!bus.o_done && n < 3000) begin
         if (bus.o_spks) hi++;
         tick();
         n++;
      end
      check_eq("song0_len", 32'(n), 32'd506);
      check_eq("song0_spks_high", 32'(hi), 32'd120);
      tick();
      check_eq("song0_idle_busy", 32'(bus.o_busy), 32'd0);

      // Song 1 unpaused, then paused for 100 cycles mid-note
      pulse_start(1, 1'b0);
      run_to_done(3000, n);
      check_eq("song1_len", 32'(n), 32'd506);
      tick();
      pulse_start(1, 1'b0);
      n = 0;
      for (int i = 0; i < 120; i++) begin tick(); n++; end
      bus.i_pause = 1'b1;
      for (int i = 0; i < 100; i++) begin tick(); n++; end
      bus.i_pause = 1'b0;
      while (!bus.o_done && n < 3000) begin tick(); n++; end
      check_eq("pause_len", 32'(n), 32'd606);
      tick();

      // Song 2 looping: no DONE across several loops
      pulse_start(2, 1'b1);
      dones = 0;
      for (int i = 0; i < 1300; i++) begin
         if (bus.o_done) dones++;
         tick();
      end
      check_eq("loop_dones", 32'(dones), 32'd0);
      bus.i_loop = 1'b0;
      run_to_done(600, n);
      tick();

      // START and STOP in the same cycle
      bus.i_song_sel = 2'd1;
      bus.i_start = 1'b1;
      bus.i_stop = 1'b1;
      tick();
      bus.i_start = 1'b0;
      bus.i_stop = 1'b0;
      tick();
      check_eq("startstop_busy", 32'(bus.o_busy), 32'd0);

      // Reset mid-note
      pulse_start(1, 1'b0);
      for (int i = 0; i < 40; i++) tick();
      rst = 1'b1;
      model_reset();
      tick();
      check_eq("rst_spks", 32'(bus.o_spks), 32'd0);
      rst = 1'b0;
      tick();

      // Random control traffic over short random songs
      for (int i = 0; i < 8; i++) mem[512 + i] = (i == 7) ? 4'd15 : 4'($urandom_range(0, 15));
      for (int i = 0; i < 6000; i++) begin
         bus.i_start = ($urandom_range(0, 149) == 0);
         bus.i_stop = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 49) == 0) bus.i_pause = ~bus.i_pause;
         if ($urandom_range(0, 199) == 0) bus.i_loop = ~bus.i_loop;
         bus.i_song_sel = 2'($urandom_range(0, 2));
         tick();
      end
      bus.i_start = 1'b0;
      bus.i_pause = 1'b0;
      bus.i_loop = 1'b0;
      bus.i_stop = 1'b1;
      tick();
      bus.i_stop = 1'b0;

      // Full-depth song: ends after idx 255 without entering the next region
      pulse_start(3, 1'b0);
      run_to_done(70000, n);
      check_eq("full_song_len", 32'(n), 32'(256 * 252));
      tick();
      check_eq("full_song_addr", 32'(bus.o_rom_addr), 32'h3FF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
